// File: rtl/adc_acq_sequencer_if.sv
// Control, configuration and status bundle between the register file /
// conversion-trigger path (master) and the acquisition sequencer (slave).
//
// Handshake semantics: there is no valid/ready flow control on this bus.
// start, abort and sample_valid are single-cycle pulses sampled on aclk.
// done and aborted are single-cycle pulses. last is combinational and is
// valid only in the same cycle as a sample_valid pulse. Config fields are
// sampled only in the cycle an accepted start is seen.
interface adc_acq_sequencer_if #(
   parameter int CNT_W   = 32,
   parameter int FRAME_W = 16
);
   logic               start;
   logic               abort;
   logic [CNT_W-1:0]   frame_len;
   logic [FRAME_W-1:0] frame_count;
   logic [CNT_W-1:0]   holdoff;
   logic               sample_valid;
   logic               run;
   logic               last;
   logic               busy;
   logic               done;
   logic               aborted;
   logic               cfg_err;
   logic               overrun;
   logic [FRAME_W-1:0] frame_idx;
   logic [CNT_W-1:0]   sample_idx;
   logic [1:0]         dbg_state;

   modport master (
      output start, abort, frame_len, frame_count, holdoff, sample_valid,
      input  run, last, busy, done, aborted, cfg_err, overrun,
             frame_idx, sample_idx, dbg_state
   );

   modport slave (
      input  start, abort, frame_len, frame_count, holdoff, sample_valid,
      output run, last, busy, done, aborted, cfg_err, overrun,
             frame_idx, sample_idx, dbg_state
   );
endinterface

// File: rtl/adc_acq_sequencer.sv
// Frame-based ADC acquisition sequencer. Gates the conversion engine with
// run, counts samples per frame, flags the last sample of each frame for the
// DMA path, and repeats frames with a programmable hold-off gap.
module adc_acq_sequencer #(
   parameter int CNT_W   = 32,
   parameter int FRAME_W = 16
) (
   input logic                aclk,
   input logic                areset,
   adc_acq_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_HOLDOFF = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
   localparam logic [FRAME_W-1:0] FRAME_ONE = FRAME_W'(1);

   state_t             state;
   logic [CNT_W-1:0]   len_q;
   logic [FRAME_W-1:0] count_q;
   logic [CNT_W-1:0]   holdoff_q;
   logic [CNT_W-1:0]   hold_cnt;
   logic [CNT_W-1:0]   sample_idx;
   logic [FRAME_W-1:0] frame_idx;
   logic               run_q;
   logic               busy_q;
   logic               done_q;
   logic               aborted_q;
   logic               cfg_err_q;
   logic               overrun_q;
   logic               abort_hit;
   logic               sample_hit;
   logic               last_hit;
   logic [FRAME_W-1:0] frame_next;

   // Abort only acts outside IDLE; a sample in the abort cycle is dropped.
   assign abort_hit  = bus.abort && (state != ST_IDLE);
   assign sample_hit = bus.sample_valid && (state == ST_RUN) && !bus.abort;
   assign last_hit   = sample_hit && (sample_idx == len_q - CNT_ONE);
   assign frame_next = frame_idx + FRAME_ONE;

   // Sequencer FSM with registered status outputs.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state      <= ST_IDLE;
         len_q      <= '0;
         count_q    <= '0;
         holdoff_q  <= '0;
         hold_cnt   <= '0;
         sample_idx <= '0;
         frame_idx  <= '0;
         run_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         aborted_q  <= 1'b0;
         cfg_err_q  <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         aborted_q <= 1'b0;

         if (abort_hit) begin
            state      <= ST_IDLE;
            run_q      <= 1'b0;
            busy_q     <= 1'b0;
            aborted_q  <= 1'b1;
            sample_idx <= '0;
            frame_idx  <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (bus.start && !bus.abort) begin
                     if (bus.frame_len != '0) begin
                        len_q      <= bus.frame_len;
                        count_q    <= bus.frame_count;
                        holdoff_q  <= bus.holdoff;
                        sample_idx <= '0;
                        frame_idx  <= '0;
                        cfg_err_q  <= 1'b0;
                        overrun_q  <= 1'b0;
                        run_q      <= 1'b1;
                        busy_q     <= 1'b1;
                        state      <= ST_RUN;
                     end else begin
                        cfg_err_q <= 1'b1;
                     end
                  end
               end
               ST_RUN: begin
                  if (last_hit) begin
                     sample_idx <= '0;
                     frame_idx  <= frame_next;
                     if ((count_q != '0) && (frame_next == count_q)) begin
                        state  <= ST_DONE;
                        run_q  <= 1'b0;
                        done_q <= 1'b1;
                     end else if (holdoff_q != '0) begin
                        state    <= ST_HOLDOFF;
                        run_q    <= 1'b0;
                        hold_cnt <= holdoff_q;
                     end
                  end else if (sample_hit) begin
                     sample_idx <= sample_idx + CNT_ONE;
                  end
               end
               ST_HOLDOFF: begin
                  // Leaving when the counter shows 1 keeps run low exactly holdoff cycles.
                  if (hold_cnt == CNT_ONE) begin
                     state <= ST_RUN;
                     run_q <= 1'b1;
                  end else begin
                     hold_cnt <= hold_cnt - CNT_ONE;
                  end
               end
               ST_DONE: begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
               end
               default: state <= ST_IDLE;
            endcase
         end

         // A sample outside RUN is stray; this set overrides a same-cycle start clear.
         if (bus.sample_valid && (state != ST_RUN)) begin
            overrun_q <= 1'b1;
         end
      end
   end

   assign bus.run        = run_q;
   assign bus.last       = last_hit;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.aborted    = aborted_q;
   assign bus.cfg_err    = cfg_err_q;
   assign bus.overrun    = overrun_q;
   assign bus.frame_idx  = frame_idx;
   assign bus.sample_idx = sample_idx;
   assign bus.dbg_state  = state;

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// Directed testbench for adc_acq_sequencer with hand-computed expectations.
module tb_adc_acq_sequencer;
   localparam int CNT_W   = 32;
   localparam int FRAME_W = 16;

   logic aclk = 1'b0;
   logic areset;
   int   n_checks = 0;
   int   n_pass   = 0;

   adc_acq_sequencer_if #(.CNT_W(CNT_W), .FRAME_W(FRAME_W)) bus ();

   adc_acq_sequencer #(.CNT_W(CNT_W), .FRAME_W(FRAME_W)) dut (
      .aclk   (aclk),
      .areset (areset),
      .bus    (bus)
   );

   // clock
   always #5 aclk = ~aclk;

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   // One-cycle sample pulse; reports whether last accompanied it.
   task automatic sample(output logic saw_last);
      bus.sample_valid = 1'b1;
      #1 saw_last = bus.last;
      @(posedge aclk);
      #1;
      bus.sample_valid = 1'b0;
   endtask

   task automatic start_seq(input logic [CNT_W-1:0] len, input logic [FRAME_W-1:0] cnt,
                            input logic [CNT_W-1:0] hold);
      bus.frame_len   = len;
      bus.frame_count = cnt;
      bus.holdoff     = hold;
      bus.start       = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   initial begin
      logic l;
      int   lasts;
      int   dones;
      int   low;

      areset           = 1'b1;
      bus.start        = 1'b0;
      bus.abort        = 1'b0;
      bus.frame_len    = '0;
      bus.frame_count  = '0;
      bus.holdoff      = '0;
      bus.sample_valid = 1'b0;

      // reset state
      #22;
      check("rst_run", bus.run, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_flags", {bus.done, bus.aborted, bus.cfg_err, bus.overrun}, 0);
      check("rst_idx", {bus.frame_idx, bus.sample_idx}, 0);
      check("rst_state", bus.dbg_state, 0);
      step();
      areset = 1'b0;
      step();

      // single frame, config changed after start must not matter
      start_seq(4, 1, 0);
      bus.frame_len = 2;
      check("sf_run", bus.run, 1);
      check("sf_busy", bus.busy, 1);
      for (int i = 0; i < 4; i++) begin
         step();
         step();
         sample(l);
         check($sformatf("sf_last%0d", i), l, (i == 3) ? 1 : 0);
      end
      check("sf_done", bus.done, 1);
      check("sf_run_done", bus.run, 0);
      check("sf_busy_done", bus.busy, 1);
      step();
      check("sf_done_pulse", bus.done, 0);
      check("sf_busy_end", bus.busy, 0);
      check("sf_frame_idx", bus.frame_idx, 1);

      // multi-frame with 5-cycle hold-off gap
      start_seq(2, 3, 5);
      lasts = 0;
      for (int f = 0; f < 3; f++) begin
         check($sformatf("mf_frame_idx%0d", f), bus.frame_idx, f);
         check($sformatf("mf_run%0d", f), bus.run, 1);
         sample(l);
         lasts += int'(l);
         step();
         sample(l);
         lasts += int'(l);
         if (f < 2) begin
            low = 0;
            while (bus.run == 1'b0 && low < 20) begin
               low++;
               step();
            end
            check($sformatf("mf_gap%0d", f), low, 5);
         end else begin
            check("mf_done", bus.done, 1);
         end
      end
      check("mf_lasts", lasts, 3);
      step();
      check("mf_idle", bus.busy, 0);

      // back-to-back frames
      start_seq(3, 2, 0);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("bb_run%0d", i), bus.run, 1);
         sample(l);
         check($sformatf("bb_last%0d", i), l, (i == 2 || i == 5) ? 1 : 0);
      end
      check("bb_done", bus.done, 1);
      step();

      // abort mid-frame together with a sample
      start_seq(8, 0, 0);
      for (int i = 0; i < 3; i++) sample(l);
      check("ab_sidx_pre", bus.sample_idx, 3);
      bus.sample_valid = 1'b1;
      bus.abort        = 1'b1;
      #1 check("ab_no_last", bus.last, 0);
      @(posedge aclk);
      #1;
      bus.sample_valid = 1'b0;
      bus.abort        = 1'b0;
      check("ab_aborted", bus.aborted, 1);
      check("ab_run", bus.run, 0);
      check("ab_busy", bus.busy, 0);
      check("ab_sidx", bus.sample_idx, 0);
      check("ab_overrun_pre", bus.overrun, 0);
      step();
      check("ab_pulse", bus.aborted, 0);
      sample(l);
      check("ab_overrun", bus.overrun, 1);

      // illegal config, then busy start ignored
      start_seq(0, 1, 0);
      check("ce_err", bus.cfg_err, 1);
      check("ce_busy", bus.busy, 0);
      check("ce_overrun_kept", bus.overrun, 1);
      start_seq(4, 1, 0);
      check("ce_err_clr", bus.cfg_err, 0);
      check("ce_overrun_clr", bus.overrun, 0);
      check("ce_busy_on", bus.busy, 1);
      sample(l);
      sample(l);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check("ce_restart_sidx", bus.sample_idx, 2);
      sample(l);
      sample(l);
      check("ce_last", l, 1);
      check("ce_done", bus.done, 1);
      step();

      // infinite frames of length 1
      start_seq(1, 0, 0);
      lasts = 0;
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         sample(l);
         lasts += int'(l);
         dones += int'(bus.done);
      end
      check("inf_lasts", lasts, 20);
      check("inf_dones", dones, 0);
      check("inf_frame_idx", bus.frame_idx, 20);
      check("inf_busy", bus.busy, 1);
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      step();

      // asynchronous reset mid-frame
      start_seq(4, 1, 0);
      sample(l);
      sample(l);
      check("ar_sidx_pre", bus.sample_idx, 2);
      #3 areset = 1'b1;
      #1;
      check("ar_run", bus.run, 0);
      check("ar_busy", bus.busy, 0);
      check("ar_idx", {bus.frame_idx, bus.sample_idx}, 0);
      check("ar_state", bus.dbg_state, 0);
      check("ar_flags", {bus.done, bus.aborted, bus.cfg_err, bus.overrun}, 0);
      step();
      areset = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
